// File: rtl/route_sequencer.sv
// route_sequencer: automatic route scheduler in front of the semi-auto
// crossroad FSM. Stores a programmed list of turn commands and hands one
// command to the FSM at each crossroad stop, waiting for it to be accepted.
module route_sequencer #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 50
) (
  input  logic       clk_20ms,
  input  logic       rst,
  input  logic       en,
  input  logic       prog_en,
  input  logic [1:0] cmd_in,
  input  logic       cmd_push,
  input  logic       start,
  input  logic       clear,
  input  logic       loop,
  input  logic [1:0] fsm_state,
  output logic       straight,
  output logic       left,
  output logic       right,
  output logic       back,
  output logic [3:0] route_len,
  output logic [3:0] route_idx,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       fault
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] FSM_WAIT    = 2'b00;
  localparam logic [1:0] FSM_FORWARD = 2'b01;

  typedef enum logic [2:0] {
    IDLE, RUN_WAIT, ISSUE, TRAVEL, DONE_S, FAULT_S
  } state_t;

  state_t          state;
  logic [1:0]      mem [DEPTH];
  logic [CW-1:0]   cnt;
  logic [3:0]      cmd_q;      // {straight, left, right, back}
  logic [3:0]      idx_nxt;
  logic            push_ok;

  assign {straight, left, right, back} = cmd_q;
  assign busy    = (state == RUN_WAIT) || (state == ISSUE) || (state == TRAVEL);
  assign done    = (state == DONE_S);
  assign fault   = (state == FAULT_S);
  assign idx_nxt = route_idx + 4'd1;
  assign push_ok = (state == IDLE) && cmd_push && prog_en && (route_len < 4'(DEPTH));

  function automatic logic [3:0] decode(input logic [1:0] c);
    case (c)
      2'b00:   decode = 4'b1000;
      2'b01:   decode = 4'b0100;
      2'b10:   decode = 4'b0010;
      default: decode = 4'b0001;
    endcase
  endfunction

  // Command storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk_20ms) begin
    if (!rst && !clear && push_ok)
      mem[route_len[IW-1:0]] <= cmd_in;
  end

  // Sequencer FSM: rst > clear > en drop > per-state behaviour.
  always_ff @(posedge clk_20ms) begin
    if (rst) begin
      state     <= IDLE;
      route_len <= '0;
      route_idx <= '0;
      cmd_q     <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
    end else if (clear) begin
      state     <= IDLE;
      route_len <= '0;
      route_idx <= '0;
      cmd_q     <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
    end else if (!en && (state inside {RUN_WAIT, ISSUE, TRAVEL, DONE_S})) begin
      // Leaving auto mode keeps the programmed route but rewinds it.
      state     <= IDLE;
      route_idx <= '0;
      cmd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_push && prog_en) begin
            if (route_len < 4'(DEPTH)) route_len <= route_len + 4'd1;
            else                       overflow  <= 1'b1;
          end
          if (start && en && !prog_en && (route_len != 4'd0)) begin
            route_idx <= '0;
            state     <= RUN_WAIT;
          end
        end
        RUN_WAIT: begin
          // FSM is parked at a crossroad: present the next command.
          if (fsm_state == FSM_WAIT) begin
            cnt   <= '0;
            cmd_q <= decode(mem[route_idx[IW-1:0]]);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + CW'(1);
          if (fsm_state != FSM_WAIT) begin
            // Accepted; an ack on the timeout tick still wins.
            cmd_q <= '0;
            if (idx_nxt == route_len) begin
              if (loop) begin
                route_idx <= '0;
                state     <= TRAVEL;
              end else begin
                route_idx <= route_len;
                state     <= DONE_S;
              end
            end else begin
              route_idx <= idx_nxt;
              state     <= TRAVEL;
            end
          end else if (cnt + CW'(1) == CW'(ACK_TIMEOUT)) begin
            cmd_q <= '0;
            state <= FAULT_S;
          end
        end
        TRAVEL: begin
          // Wait for forward motion so one crossroad consumes one command.
          if (fsm_state == FSM_FORWARD) state <= RUN_WAIT;
        end
        DONE_S: begin
          if (start) begin
            route_idx <= '0;
            state     <= RUN_WAIT;
          end
        end
        FAULT_S: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// Directed bench for route_sequencer with hand-computed expectations.
module tb_route_sequencer;

  logic       clk_20ms = 1'b0;
  logic       rst = 1'b1, en = 1'b0, prog_en = 1'b0, cmd_push = 1'b0;
  logic       start = 1'b0, clear = 1'b0, loop = 1'b0;
  logic [1:0] cmd_in = 2'b00, fsm_state = 2'b00;
  logic       straight, left, right, back, busy, done, overflow, fault;
  logic [3:0] route_len, route_idx, cmds;

  int errors = 0;
  int checks = 0;

  assign cmds = {straight, left, right, back};

  route_sequencer #(.DEPTH(8), .ACK_TIMEOUT(50)) dut (
    .clk_20ms(clk_20ms), .rst(rst), .en(en), .prog_en(prog_en),
    .cmd_in(cmd_in), .cmd_push(cmd_push), .start(start), .clear(clear),
    .loop(loop), .fsm_state(fsm_state),
    .straight(straight), .left(left), .right(right), .back(back),
    .route_len(route_len), .route_idx(route_idx), .busy(busy), .done(done),
    .overflow(overflow), .fault(fault)
  );

  always #5 clk_20ms = ~clk_20ms;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_20ms);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] c);
    cmd_in = c; cmd_push = 1'b1;
    step();
    cmd_push = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    rst = 1'b0;
    check("rst_cmds", cmds, 4'b0000);
    check("rst_len", route_len, 4'd0);
    check("rst_idx", route_idx, 4'd0);
    check("rst_flags", {busy, done, overflow, fault}, 4'b0000);

    // 1: three-command route, left/right/straight
    en = 1'b1; prog_en = 1'b1;
    push(2'b01); push(2'b10); push(2'b00);
    check("t1_len", route_len, 4'd3);
    prog_en = 1'b0; fsm_state = 2'b00;
    pulse_start();
    check("t1_busy", 4'(busy), 4'd1);
    step();
    check("t1_left", cmds, 4'b0100);
    fsm_state = 2'b10; step();
    check("t1_ack1_cmds", cmds, 4'b0000);
    check("t1_ack1_idx", route_idx, 4'd1);
    fsm_state = 2'b11; step();
    fsm_state = 2'b01; step();
    check("t1_travel_cmds", cmds, 4'b0000);
    fsm_state = 2'b00; step();
    check("t1_right", cmds, 4'b0010);
    fsm_state = 2'b10; step();
    check("t1_ack2_idx", route_idx, 4'd2);
    fsm_state = 2'b01; step();
    fsm_state = 2'b00; step();
    check("t1_straight", cmds, 4'b1000);
    fsm_state = 2'b10; step();
    check("t1_done_flags", {busy, done}, 4'b0001);
    check("t1_done_idx", route_idx, 4'd3);
    check("t1_done_cmds", cmds, 4'b0000);
    prog_en = 1'b1; push(2'b11); prog_en = 1'b0;
    check("t1_done_nopush", route_len, 4'd3);

    // 2: overflow on the ninth push
    pulse_clear();
    check("t2_clear_done", 4'(done), 4'd0);
    prog_en = 1'b1;
    for (int i = 0; i < 9; i++) push(2'(i));
    check("t2_len", route_len, 4'd8);
    check("t2_ovf", 4'(overflow), 4'd1);
    pulse_clear();
    check("t2_clr_len", route_len, 4'd0);
    check("t2_clr_ovf", 4'(overflow), 4'd0);

    // 3: acknowledge timeout
    push(2'b01); prog_en = 1'b0; fsm_state = 2'b00;
    pulse_start();
    step();
    check("t3_issue", cmds, 4'b0100);
    step(49);
    check("t3_pre_timeout", {fault, left, 2'b00}, 4'b0100);
    step();
    check("t3_fault", 4'(fault), 4'd1);
    check("t3_fault_cmds", cmds, 4'b0000);
    pulse_start();
    check("t3_start_ign", {busy, fault, 2'b00}, 4'b0100);
    pulse_clear();
    check("t3_clear", {busy, done, fault, 1'b0}, 4'b0000);

    // 4: looping single back command, ack on the timeout tick
    loop = 1'b1; prog_en = 1'b1; push(2'b11); prog_en = 1'b0;
    pulse_start();
    step();
    check("t4_back1", cmds, 4'b0001);
    step(49);
    fsm_state = 2'b10; step();
    check("t4_late_ack_fault", 4'(fault), 4'd0);
    check("t4_late_ack_busy", 4'(busy), 4'd1);
    check("t4_idx0", route_idx, 4'd0);
    fsm_state = 2'b01; step();
    fsm_state = 2'b00; step();
    check("t4_back2", cmds, 4'b0001);
    fsm_state = 2'b10; step();
    check("t4_idx_stays", route_idx, 4'd0);

    // 5: drop en mid-ISSUE, then ignored starts
    fsm_state = 2'b01; step();
    fsm_state = 2'b00; step();
    check("t5_issue", cmds, 4'b0001);
    en = 1'b0; step();
    check("t5_idle_cmds", cmds, 4'b0000);
    check("t5_len_kept", route_len, 4'd1);
    check("t5_idx0", route_idx, 4'd0);
    check("t5_not_busy", 4'(busy), 4'd0);
    en = 1'b1; prog_en = 1'b1; pulse_start(); prog_en = 1'b0;
    check("t5_start_prog", 4'(busy), 4'd0);
    pulse_clear();
    pulse_start();
    check("t5_start_empty", 4'(busy), 4'd0);

    // 6: reset during TRAVEL
    loop = 1'b0; prog_en = 1'b1; push(2'b00); push(2'b01); prog_en = 1'b0;
    pulse_start();
    step();
    check("t6_issue", cmds, 4'b1000);
    fsm_state = 2'b10; step();
    check("t6_travel", {busy, done, 2'b00}, 4'b1000);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_cmds", cmds, 4'b0000);
    check("t6_rst_flags", {busy, done, overflow, fault}, 4'b0000);
    check("t6_rst_len", route_len, 4'd0);
    check("t6_rst_idx", route_idx, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
